dma_cfg_frontend: RTL

Register-file responder for the DMA engine's configuration slave port (crossbar slave SDMA, base 0x5000_0000, 4 KiB window). It accepts single-beat memory-style requests from the core, holds source/destination/length registers, and launches a transfer descriptor toward the DMA backend when software reads the NEXT_ID register. It also tracks completions from the backend and raises a completion interrupt.

---
 rtl/dma_cfg_pkg.sv | 46 ++++
 rtl/dma_id_counter.sv | 34 +++
 rtl/dma_cfg_frontend.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_cfg_pkg
// Purpose  : Register map, CONF bit index and descriptor type for the DMA
//            configuration front end.
// Revision : 1.0  initial release
// ============================================================================
package dma_cfg_pkg;

    localparam logic [11:0] REG_SRC     = 12'h000;
    localparam logic [11:0] REG_DST     = 12'h008;
    localparam logic [11:0] REG_LEN     = 12'h010;
    localparam logic [11:0] REG_CONF    = 12'h018;
    localparam logic [11:0] REG_STATUS  = 12'h020;
    localparam logic [11:0] REG_NEXT_ID = 12'h028;
    localparam logic [11:0] REG_DONE_ID = 12'h030;

    localparam int CONF_IRQ_EN_BIT = 0;

    localparam int DESC_ADDR_W = 64;
    localparam int DESC_LEN_W  = 64;
    localparam int DESC_ID_W   = 32;

    // Sized for the widest build; the top slices fields down to its parameters.
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src;
        logic [DESC_ADDR_W-1:0] dst;
        logic [DESC_LEN_W-1:0]  len;
        logic [DESC_ID_W-1:0]   id;
    } dma_desc_t;

    function automatic logic [63:0] apply_be(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] merged;
        merged = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_id_counter.sv
`default_nettype none
// ============================================================================
// Module   : dma_id_counter
// Purpose  : Transfer ID counter; wraps from all-ones to 1 so 0 stays "none".
// Revision : 1.0  initial release
// ============================================================================
module dma_id_counter #(
    parameter int IdWidth = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [IdWidth-1:0] value
);

    logic [IdWidth-1:0] w_value_next;

    always_comb begin
        w_value_next = value + IdWidth'(1);
        if (value == {IdWidth{1'b1}}) begin
            w_value_next = IdWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc) begin
            value <= w_value_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_cfg_frontend.sv
`default_nettype none
// ============================================================================
// Module   : dma_cfg_frontend
// Purpose  : DMA configuration register responder; a NEXT_ID read launches a
//            descriptor, completions advance DONE_ID and raise an interrupt.
// Revision : 1.0  initial release
// ============================================================================
module dma_cfg_frontend
    import dma_cfg_pkg::*;
#(
    parameter int AddrWidth = 64,
    parameter int IdWidth   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [11:0]          addr_i,
    input  logic [63:0]          wdata_i,
    input  logic [7:0]           be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [63:0]          rdata_o,
    output logic                 err_o,
    output logic                 desc_valid_o,
    input  logic                 desc_ready_i,
    output logic [AddrWidth-1:0] desc_src_o,
    output logic [AddrWidth-1:0] desc_dst_o,
    output logic [63:0]          desc_len_o,
    output logic [IdWidth-1:0]   desc_id_o,
    input  logic                 done_i,
    output logic                 irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [63:0]        r_src;
    logic [63:0]        r_dst;
    logic [63:0]        r_len;
    logic               r_irq_en;
    logic [63:0]        r_rdata;
    logic               r_err;
    logic               r_irq;
    dma_desc_t          r_desc;

    logic [IdWidth-1:0] w_next_id;
    logic [IdWidth-1:0] w_done_id;
    logic [IdWidth-1:0] w_next_id_inc;
    logic [31:0]        w_desc_id_ext;
    logic [11:0]        w_off;
    logic               w_gnt;
    logic               w_handshake;
    logic               w_busy;
    logic               w_done_ok;
    logic               w_is_rw;
    logic               w_is_ro;
    logic               w_err;
    logic               w_launch;
    logic [63:0]        w_rd;
    logic [63:0]        w_old;
    logic [63:0]        w_wmerge;

    assign w_off       = addr_i & 12'hFF8;
    assign w_gnt       = req_i && (r_state == ST_IDLE);
    assign w_handshake = (r_state == ST_LAUNCH) && desc_ready_i;
    assign w_busy      = (w_next_id != w_done_id);
    // Completions beyond the last launched ID are spurious and dropped.
    assign w_done_ok   = done_i && w_busy;

    assign w_is_rw  = (w_off == REG_SRC) || (w_off == REG_DST) ||
                      (w_off == REG_LEN) || (w_off == REG_CONF);
    assign w_is_ro  = (w_off == REG_STATUS) || (w_off == REG_NEXT_ID) ||
                      (w_off == REG_DONE_ID);
    assign w_err    = we_i ? !w_is_rw : !(w_is_rw || w_is_ro);
    assign w_launch = !we_i && (w_off == REG_NEXT_ID) && (r_len != '0);

    dma_id_counter #(.IdWidth(IdWidth)) u_next_id (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (w_handshake),
        .value (w_next_id)
    );

    dma_id_counter #(.IdWidth(IdWidth)) u_done_id (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (w_done_ok),
        .value (w_done_id)
    );

    always_comb begin
        w_next_id_inc = w_next_id + IdWidth'(1);
        if (w_next_id == {IdWidth{1'b1}}) begin
            w_next_id_inc = IdWidth'(1);
        end
        w_desc_id_ext                = '0;
        w_desc_id_ext[IdWidth-1:0]   = w_next_id_inc;
    end

    // Read mux and the current value of the write target for byte merging.
    always_comb begin
        w_rd  = '0;
        w_old = '0;
        case (w_off)
            REG_SRC:     begin w_rd = r_src; w_old = r_src; end
            REG_DST:     begin w_rd = r_dst; w_old = r_dst; end
            REG_LEN:     begin w_rd = r_len; w_old = r_len; end
            REG_CONF: begin
                w_rd[CONF_IRQ_EN_BIT]  = r_irq_en;
                w_old[CONF_IRQ_EN_BIT] = r_irq_en;
            end
            REG_STATUS: begin
                w_rd[0] = w_busy;
                w_rd[1] = desc_valid_o;
            end
            REG_DONE_ID: w_rd[IdWidth-1:0] = w_done_id;
            default:     w_rd = '0;
        endcase
        if (we_i) begin
            w_rd = '0;
        end
        w_wmerge = apply_be(w_old, wdata_i, be_i);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt) begin
                    w_state_next = w_launch ? ST_LAUNCH : ST_RESP;
                end
            end
            ST_LAUNCH: begin
                if (desc_ready_i) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_irq    <= 1'b0;
            r_desc   <= '0;
        end else begin
            r_irq <= w_done_ok && r_irq_en;
            if (w_gnt) begin
                r_rdata <= w_rd;
                r_err   <= w_err;
                if (we_i && !w_err) begin
                    case (w_off)
                        REG_SRC:  r_src    <= w_wmerge;
                        REG_DST:  r_dst    <= w_wmerge;
                        REG_LEN:  r_len    <= w_wmerge;
                        REG_CONF: r_irq_en <= w_wmerge[CONF_IRQ_EN_BIT];
                        default:  ;
                    endcase
                end
                if (w_launch) begin
                    r_desc.src <= r_src;
                    r_desc.dst <= r_dst;
                    r_desc.len <= r_len;
                    r_desc.id  <= w_desc_id_ext;
                end
            end else if (w_handshake) begin
                r_rdata <= {32'b0, r_desc.id};
            end
        end
    end

    assign gnt_o        = w_gnt;
    assign rvalid_o     = (r_state == ST_RESP);
    assign rdata_o      = r_rdata;
    assign err_o        = r_err;
    assign desc_valid_o = (r_state == ST_LAUNCH);
    assign desc_src_o   = r_desc.src[AddrWidth-1:0];
    assign desc_dst_o   = r_desc.dst[AddrWidth-1:0];
    assign desc_len_o   = r_desc.len;
    assign desc_id_o    = r_desc.id[IdWidth-1:0];
    assign irq_o        = r_irq;

endmodule
`default_nettype wire
